// File: rtl/ws2812_strip_driver.sv
// WS2812 chain driver: host-writable LENGTH-pixel frame store serialised MSB-first onto DO,
// followed by a latch low period; supports start/busy/done handshake and auto-refresh.
module ws2812_strip_driver #(
  parameter int LENGTH = 2,
  parameter int T0H    = 20,
  parameter int T1H    = 40,
  parameter int TBIT   = 62,
  parameter int TRESET = 2600,
  parameter int ADDR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic              auto_refresh,
  output logic              DO,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_MAX = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [CNT_W-1:0]  C_BIT_LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0]  C_RST_LAST = CNT_W'(TRESET - 1);
  localparam logic [CNT_W-1:0]  C_T0H      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  C_T1H      = CNT_W'(T1H);
  localparam logic [ADDR_W-1:0] C_PIX_LAST = ADDR_W'(LENGTH - 1);
  localparam logic [ADDR_W:0]   C_LEN      = (ADDR_W + 1)'(LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_LATCH} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [23:0]       r_mem [DEPTH];
  logic [23:0]       r_shift;
  logic [23:0]       r_next_pix;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_bit;
  logic [ADDR_W-1:0] r_pix;
  logic              r_do;
  logic              r_busy;
  logic              r_done;

  logic              w_wr_ok;
  logic              w_bit_end;
  logic              w_last_pix;
  logic              w_last_bit;
  logic              w_latch_end;
  logic              w_frame_go;
  logic              w_prefetch;
  logic              w_cur_bit;
  logic [ADDR_W-1:0] w_pix_inc;
  logic              w_do_next;
  logic              w_busy_next;
  logic              w_done_next;

  assign w_wr_ok     = {1'b0, wr_addr} < C_LEN;
  assign w_bit_end   = (r_cnt == C_BIT_LAST);
  assign w_last_pix  = (r_pix == C_PIX_LAST);
  assign w_last_bit  = w_bit_end && (r_bit == 5'd0) && w_last_pix;
  assign w_latch_end = (r_cnt == C_RST_LAST);
  assign w_frame_go  = ((r_state == S_IDLE) && start) ||
                       ((r_state == S_LATCH) && w_latch_end && auto_refresh);
  // Next pixel is fetched on the edge that opens the bit-0 period of the current one
  assign w_prefetch  = (r_state == S_SEND) && w_bit_end && (r_bit == 5'd1) && !w_last_pix;
  assign w_cur_bit   = r_shift[r_bit];
  assign w_pix_inc   = r_pix + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SEND;
      S_SEND:  if (w_last_bit) w_state_next = S_LATCH;
      S_LATCH: if (w_latch_end) w_state_next = auto_refresh ? S_SEND : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_do_next   = 1'b0;
    w_busy_next = (r_state != S_IDLE);
    w_done_next = (r_state == S_LATCH) && w_latch_end;
    if (r_state == S_SEND) begin
      w_do_next = (r_cnt < (w_cur_bit ? C_T1H : C_T0H));
    end
  end

  // Outputs lag the state by one cycle so DO is purely registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_do   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_do   <= w_do_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit      <= 5'd23;
      r_pix      <= '0;
      r_shift    <= '0;
      r_next_pix <= '0;
    end else begin
      if (w_frame_go) begin
        r_cnt   <= '0;
        r_bit   <= 5'd23;
        r_pix   <= '0;
        r_shift <= r_mem[0];
      end else begin
        case (r_state)
          S_SEND: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (r_bit == 5'd0) begin
                r_bit <= 5'd23;
                if (!w_last_pix) begin
                  r_pix   <= w_pix_inc;
                  r_shift <= r_next_pix;
                end
              end else begin
                r_bit <= r_bit - 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_LATCH: r_cnt <= w_latch_end ? '0 : r_cnt + 1'b1;
          default: r_cnt <= '0;
        endcase
      end
      if (w_prefetch) begin
        r_next_pix <= r_mem[w_pix_inc];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign DO         = r_do;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: frame-timing model computed from elapsed cycles plus
// literal waveform checks, with random pixel data and random mid-frame writes.
module tb_ws2812_strip_driver;
  localparam int L        = 2;
  localparam int T0H      = 20;
  localparam int T1H      = 40;
  localparam int TBIT     = 62;
  localparam int TRESET   = 2600;
  localparam int SEND_LEN = L * 24 * TBIT;
  localparam int FRAME    = SEND_LEN + TRESET;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        wr_en = 0;
  logic [1:0]  wr_addr = 0;
  logic [23:0] wr_data = 0;
  logic        start = 0;
  logic        auto_refresh = 0;
  logic        do_o, busy, frame_done;

  logic        wr_en1 = 0;
  logic [0:0]  wr_addr1 = 0;
  logic        start1 = 0;
  logic        auto1 = 0;
  logic        do1, busy1, fd1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ws2812_strip_driver #(.LENGTH(L), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET), .ADDR_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .auto_refresh(auto_refresh), .DO(do_o), .busy(busy), .frame_done(frame_done)
  );

  ws2812_strip_driver #(.LENGTH(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data),
    .start(start1), .auto_refresh(auto1), .DO(do1), .busy(busy1), .frame_done(fd1)
  );

  // Behavioural model: frame start edge, per-pixel snapshot, and a shadow of the pixel store
  int          cyc = 0;
  int          c0 = 0;
  bit          cmp_en = 0;
  bit          m_active = 0, m_c0_valid = 0, m_prev_valid = 0;
  int          m_c0 = 0, m_prev_c0 = 0;
  logic [23:0] mem_m [4];
  logic [23:0] snap  [4];

  always @(posedge clk or negedge rst_n) begin : model
    int t;
    if (!rst_n) begin
      m_active = 0; m_c0_valid = 0; m_prev_valid = 0;
      for (int p = 0; p < 4; p++) mem_m[p] = '0;
    end else if (clk) begin
      cyc++;
      if (m_active) begin
        t = cyc - m_c0;
        if (t == FRAME) begin
          m_active = 0;
          if (auto_refresh) begin
            m_prev_c0 = m_c0; m_prev_valid = 1;
            m_active = 1; m_c0 = cyc; snap[0] = mem_m[0];
          end
        end else begin
          for (int p = 1; p < L; p++) if (t == (24 * p - 1) * TBIT) snap[p] = mem_m[p];
        end
      end else if (start) begin
        m_active = 1; m_c0_valid = 1; m_c0 = cyc; snap[0] = mem_m[0];
      end
      if (wr_en && int'(wr_addr) < L) mem_m[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin : compare
    logic e_do, e_busy, e_done;
    int t, k, ph, p, b;
    if (cmp_en) begin
      e_do = 0; e_busy = 0; e_done = 0;
      t = cyc - m_c0;
      if (rst_n) begin
        if (m_c0_valid && t >= 1 && t <= FRAME) begin
          e_busy = 1;
          if (t <= SEND_LEN) begin
            k = (t - 1) / TBIT; ph = (t - 1) % TBIT;
            p = k / 24; b = 23 - (k % 24);
            e_do = (ph < (snap[p][b] ? T1H : T0H));
          end else begin
            e_done = (t == FRAME);
          end
        end else if (m_prev_valid && (cyc - m_prev_c0) == FRAME) begin
          e_busy = 1; e_done = 1;
        end
      end
      n_total += 3;
      if (do_o !== e_do) begin
        n_bad++; $display("FAIL model_do cyc=%0d got=%0b expected=%0b", cyc, do_o, e_do);
      end
      if (busy !== e_busy) begin
        n_bad++; $display("FAIL model_busy cyc=%0d got=%0b expected=%0b", cyc, busy, e_busy);
      end
      if (frame_done !== e_done) begin
        n_bad++; $display("FAIL model_done cyc=%0d got=%0b expected=%0b", cyc, frame_done, e_done);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_now(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic start_frame(input bit both);
    @(negedge clk);
    start = 1; start1 = both;
    @(negedge clk);
    start = 0; start1 = 0;
    c0 = cyc;
  endtask

  task automatic wait_rel(input int r);
    for (int i = 0; i < r + 10 && (cyc - c0) < r; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (!busy && (cyc - c0) > 1) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  int lc [13] = '{1, 40, 41, 62, 63, 82, 83, 124, 125, 164, 165, 1508, 1509};
  int lv [13] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};

  initial begin : watchdog
    #1200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fd, fd1v, nd, prevd;
    bit drop, pend;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("reset_do", do_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", frame_done, 0);
    rst_n = 1;

    // Single frame on both instances; writes to 2 and 3 must be ignored
    @(negedge clk);
    wr_en1 = 1; wr_addr1 = 0;
    wr_now(2'd0, 24'hABCD00);
    wr_en1 = 0;
    wr(2'd1, 24'h00ABCD);
    wr(2'd2, 24'hFFFFFF);
    wr(2'd3, 24'hFFFFFF);
    start_frame(1);
    chk("busy_rel0", busy, 0);
    for (int i = 0; i < 13; i++) begin
      wait_rel(lc[i]);
      chk($sformatf("single_do_rel%0d", lc[i]), do_o, lv[i]);
      if (i == 0) chk("busy_rel1", busy, 1);
    end
    fd = -1; fd1v = -1;
    for (int i = 0; i < 6000 && fd < 0; i++) begin
      @(negedge clk);
      if (fd1 && fd1v < 0) fd1v = cyc - c0;
      if (frame_done) fd = cyc - c0;
    end
    chk("done_cycle", fd, 5576);
    chk("len1_done_cycle", fd1v, 4088);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("len1_busy_after", busy1, 0);
    $display("single frame: done at %0d, len1 done at %0d", fd, fd1v);

    // Start pulses while busy must be ignored
    wr(2'd0, 24'($urandom));
    wr(2'd1, 24'($urandom));
    start_frame(0);
    nd = 0;
    for (int i = 0; i < 5600; i++) begin
      @(negedge clk);
      start = ((cyc - c0) == 99) || ((cyc - c0) == 2999);
      if (frame_done) nd++;
    end
    start = 0;
    chk("start_busy_one_done", nd, 1);
    $display("start while busy: frame_done count %0d", nd);

    // Mid-frame writes: one early enough, one on the sampling edge of pixel 1
    wr(2'd0, 24'($urandom));
    wr(2'd1, 24'h000000);
    start_frame(0);
    wait_rel(199);
    wr_now(2'd1, 24'hFFFFFF);
    wait_rel(1425);
    wr_now(2'd1, 24'h123456);
    wait_rel(1528);
    chk("midwr_p1b23_hi", do_o, 1);
    wait_rel(1529);
    chk("midwr_p1b23_lo", do_o, 0);
    wait_rel(2954);
    chk("midwr_p1b0_hi", do_o, 1);
    wait_idle("midwr_idle");
    $display("mid-frame write: pixel 1 sent as ffffff");

    // Auto-refresh across three frames with random writes sprinkled in
    auto_refresh = 1;
    start_frame(0);
    nd = 0; prevd = 0; drop = 0; pend = 0;
    for (int i = 0; i < 20000 && nd < 3; i++) begin
      @(negedge clk);
      if (pend) begin chk("auto_do_rise", do_o, 1); pend = 0; end
      if (!busy) drop = 1;
      if (frame_done) begin
        nd++;
        chk("auto_period", (cyc - c0) - prevd, FRAME);
        prevd = cyc - c0;
        if (nd < 3) pend = 1;
        if (nd == 2) auto_refresh = 0;
      end
      if (((cyc - c0) % 1000) == 500) begin
        wr_en = 1; wr_addr = 2'($urandom_range(0, 3)); wr_data = 24'($urandom);
      end else begin
        wr_en = 0;
      end
    end
    wr_en = 0; auto_refresh = 0;
    chk("auto_done_count", nd, 3);
    chk("auto_busy_held", drop, 0);
    @(negedge clk);
    chk("auto_busy_end", busy, 0);
    $display("auto-refresh: %0d frames", nd);

    // Asynchronous reset mid-frame, then an all-zero frame
    start_frame(0);
    wait_rel(1000);
    #2 rst_n = 0;
    #1;
    chk("rst_do", do_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    start_frame(0);
    wait_rel(20);
    chk("zero_b23_hi", do_o, 1);
    wait_rel(21);
    chk("zero_b23_lo", do_o, 0);
    wait_rel(1509);
    chk("zero_p1_lo", do_o, 0);
    wait_idle("zero_idle");
    $display("reset mid-frame: zero frame sent");

    // Random frames with random mid-frame writes
    for (int f = 0; f < 2; f++) begin
      wr(2'd0, 24'($urandom));
      wr(2'd1, 24'($urandom));
      start_frame(0);
      for (int w = 0; w < 4; w++) begin
        wait_rel(w * 1400 + int'($urandom_range(1, 1300)));
        wr_now(2'($urandom_range(0, 3)), 24'($urandom));
      end
      wait_idle("rand_idle");
      $display("random frame %0d complete", f);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2812_strip_driver.md
# ws2812_strip_driver

Parametrised single-wire driver for a chain of WS2812-class RGB LEDs. It holds a LENGTH-pixel, 24-bit frame store that the host writes through a simple write port. On request it serialises the whole frame onto `DO` using parameter-defined bit timing, then drives the latch/reset low period. It replaces the fixed-length encoder used in FPGA bring-up: it adds host-writable pixel storage, a start/busy/done handshake, configurable timing and an auto-refresh mode.

## Interface
Parameters:
- `LENGTH`, 2: number of pixels in the chain; must be ≥ 1.
- `T0H`, 20: high time of a 0 bit, in clk cycles (400 ns at 50 MHz).
- `T1H`, 40: high time of a 1 bit, in clk cycles (800 ns).
- `TBIT`, 62: total bit period, in clk cycles (1.24 µs). Requires 0 < T0H < T1H < TBIT.
- `TRESET`, 2600: latch low time after the last bit, in clk cycles (52 µs).
- `ADDR_W`, max(1, $clog2(LENGTH)): width of the pixel address.

Ports:
- `clk`  in  1  system clock, 50 MHz nominal.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for the pixel store.
- `wr_addr`  in  ADDR_W  pixel index; writes with wr_addr ≥ LENGTH are ignored.
- `wr_data`  in  24  pixel word, sent MSB first (bit 23 first; G[23:16], R[15:8], B[7:0]).
- `start`  in  1  frame request, sampled only when idle.
- `auto_refresh`  in  1  when 1, a new frame starts immediately after each latch.
- `DO`  out  1  serial LED data line.
- `busy`  out  1  high whenever a frame or latch is in progress.
- `frame_done`  out  1  single-cycle pulse at the end of each latch period.

## Operation
- The state machine has three states: IDLE, SEND and LATCH.
- Reset behaviour (`rst_n` low, acts asynchronously):
  - DO=0, busy=0 and frame_done=0.
  - The state returns to IDLE.
  - All pixel store entries are cleared to 0.
  - Any frame in progress is abandoned.
- IDLE:
  - DO=0.
  - `start`=1 on a clock edge moves the state to SEND, with pixel 0, bit 23.
- SEND:
  - Each bit lasts exactly TBIT cycles.
  - DO is high for the first T1H cycles if the bit is 1, or the first T0H cycles if it is 0, and low for the rest of the period.
  - Bits go out 23 down to 0, then pixel 0 through LENGTH-1.
  - After bit 0 of pixel LENGTH-1, the state moves to LATCH.
- LATCH:
  - DO=0 for TRESET cycles.
  - frame_done=1 in the final LATCH cycle.
  - If `auto_refresh`=1 in that cycle, the state moves to SEND (pixel 0). Otherwise it moves to IDLE.
- `start` is ignored while busy. A `start` arriving in the final LATCH cycle is also ignored; use auto_refresh for back-to-back frames.
- Pixel sampling:
  - Pixel p>0 is copied into the shift register in the first cycle of the bit-0 period of pixel p-1.
  - Pixel 0 is copied in the cycle `start` is accepted, or in the final LATCH cycle for auto-refresh.
  - A write committed on an earlier edge is sent in this frame. A same-cycle write is not; the old value is sent.
- Writes are accepted in every state, including mid-frame.
- Counters: the bit-period counter counts 0..TBIT-1, sized $clog2(max(TBIT, TRESET)). The bit index is 5 bits. The pixel index is ADDR_W bits. Counters must never wrap beyond their terminal counts.

## Timing
- Cycle 0 is the edge where `start`=1 is sampled in IDLE. DO rises at cycle 1, and busy=1 from cycle 1.
- The first DO falling edge is at cycle 1+T1H or 1+T0H, depending on bit 23 of pixel 0.
- The SEND phase spans cycles 1 .. LENGTH·24·TBIT, with no gaps between bits or between pixels.
- LATCH spans cycles LENGTH·24·TBIT+1 .. LENGTH·24·TBIT+TRESET. frame_done=1 in the last of these.
- busy=0 from the following cycle, unless auto-refresh is active; in that case DO rises again on that cycle.
- Write latency: 1 cycle, meaning the write is visible to the sampling logic on the next edge.
- DO is a registered output with no combinational path from the inputs.

## Test plan
- Single frame:
  - Stimulus: LENGTH=2, defaults; write 0xABCD00 to address 0 and 0x00ABCD to address 1; pulse start.
  - Expect the first bit (1) to be high 40 / low 22 cycles, then bit 22 (0) high 20 / low 42.
  - Expect all 48 bits to decode correctly, frame_done at cycle 5576 and busy low at cycle 5577.
- Start while busy: pulse start at cycles 100 and 3000 of a frame -> no change to the DO waveform; exactly one frame_done.
- Mid-frame write:
  - At cycle 200, write 0xFFFFFF to address 1 -> pixel 1 is sent as all-ones (40-cycle highs).
  - A write to address 1 on the same edge as its sampling cycle (cycle 1426) -> old data is sent.
- Auto-refresh: hold auto_refresh=1 across frames -> frame_done every 5576 cycles; DO rises on the cycle immediately after each frame_done; busy stays high throughout.
- Reset mid-frame: drop rst_n at cycle 1000 -> DO, busy and frame_done go 0 immediately; a following start sends all-zero pixels (20-cycle highs only).
- Bad write and boundary: write to address 2 with LENGTH=2 -> ignored. LENGTH=1 -> frame_done at 24·62+2600 = 4088.
